psram_opi_core: RTL and testbench
=================================

Name: psram_opi_core

Overview:
Transaction engine directly downstream of the PSRAM register block. It consumes the latched CTRL/CMD/WAIT configuration and a single-transfer request (address plus 16-bit data), and drives the OPI DDR pin bundle (SCK, CE#, IO[7:0], DQS). Each request becomes one complete 2-byte OPI burst:
- command, address, latency, data, hold, recovery;
- done pulse at the end, with read data.

Parameters:
DATA_BYTES, 2, bytes per burst (fixed; the device requires a minimum 2-byte write burst).
LC_WIDTH, 8, width of the latency-count inputs.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
en_i  in  1  CTRL.EN
pscr_i  in  2  prescaler: 00=DIV4, 01=DIV8, 10=DIV16, 11=DIV32
tcsp_i  in  2  CE# setup, in half-SCK units minus 1
tchd_i  in  2  CE# hold, in half-SCK units minus 1
recy_i  in  8  CE# high recovery, in half-SCK units minus 1
wcmd_i  in  8  write command byte
rcmd_i  in  8  read command byte
wlc_i  in  8  write latency, in SCK cycles
rlc_i  in  8  read latency, in SCK cycles
xfer_valid_i  in  1  request valid
xfer_ready_o  out  1  request accepted this cycle
xfer_we_i  in  1  1=write, 0=read
xfer_addr_i  in  32  byte address (must be even)
xfer_wdata_i  in  16  write data; [15:8] is sent first
rdata_o  out  16  read data; first byte in [15:8]
done_o  out  1  one-cycle pulse when the burst completes
busy_o  out  1  high whenever state != IDLE
psram_sck_o  out  1  SCK
psram_ce_o  out  1  CE#, active low
psram_io_en_o  out  8  IO output enables
psram_io_out_o  out  8  IO output data
psram_io_in_i  in  8  IO input data
psram_dqs_en_o  out  1  DQS output enable
psram_dqs_out_o  out  1  DQS/DM output
psram_dqs_in_i  in  1  DQS input (unused this revision; read capture is clock-based)

Behaviour:
- Reset values: sck=0, ce=1, io_en=0, io_out=0, dqs_en=0, dqs_out=0, rdata=0, done=0, busy=0, xfer_ready=0. State = IDLE.
- Half-period timebase:
  - H = 2/4/8/16 clk for pscr 00/01/10/11.
  - hp_cnt counts 0..H-1 in every non-IDLE state; clears on state entry.
  - Launch point: hp_cnt==H/2-1. Edge point: hp_cnt==H-1. One "beat" = one half-period.
- pscr_i is sampled at request acceptance and held for the whole burst. All other config is read live and must be static while busy.
- xfer_ready_o = (state==IDLE) & en_i & xfer_valid_i (combinational).
  - On accept: latch we, addr, wdata; cmd = we ? wcmd : rcmd; LC = we ? wlc : rlc. Go to TCSP.
- TCSP:
  - ce=0, sck=0, io_en=0.
  - Lasts tcsp+1 beats, then INST.
- Toggling states (INST, ADDR, LATN, WDATA, RDATA):
  - sck inverts at every edge point.
  - Outputs update at every launch point.
  - Beat counter bcnt (9 bits) clears on state entry.
- INST: 2 beats. io_en=FF; io_out=cmd on both beats.
- ADDR: 4 beats. io_out = addr[31:24], [23:16], [15:8], [7:0].
  - Exit to LATN if LC!=0; otherwise to WDATA (write) or RDATA (read).
- LATN:
  - 2*LC beats; io_en=0.
  - Write only: dqs_en=1, dqs_out=0 asserted from the last latency beat onward.
- WDATA:
  - 2 beats; io_en=FF; io_out = wdata[15:8], then wdata[7:0].
  - dqs_en=1, dqs_out=0 (no mask).
- RDATA:
  - 2 beats; io_en=0.
  - io_in sampled at each edge point into rdata[15:8], then rdata[7:0].
- TCHD:
  - sck=0 (already low after an even beat count), ce=0, io_en=0, dqs_en=0.
  - Lasts tchd+1 beats.
- RECY:
  - ce=1; done_o pulses on the first cycle; rdata_o is stable from then until the next read completes.
  - Lasts recy+1 beats, then IDLE.
- SCK rising-edge count per burst: 1 + 2 + LC + 1.
- en_i deasserted mid-burst: the burst runs to completion; no new request is accepted.
- xfer_valid_i high in IDLE with en_i=0: ignored, xfer_ready_o stays 0.
- Asynchronous reset mid-burst: all outputs return to reset values immediately; there is no done pulse.
- Odd xfer_addr_i: bit 0 is forced to 0 and the request is still serviced.

Decomposition:
- The shared psram define package holds:
  - FSM state encodings (PSRAM_FSM_IDLE..RECY);
  - PSCR codes (PSRAM_PSCR_DIV*);
  - the psram_if interface, whose dut modport this block's pin ports map onto.
- One sub-module, psram_sck_gen:
  - inputs: pscr, run, clear;
  - outputs: launch/edge strobes and the sck register.
- The FSM, beat counters and data shifting stay in psram_opi_core.

Test Plan:
- Write, DIV4, tcsp=0, tchd=0, recy=0, wcmd=0xA0, wlc=2, addr=0x0000_1234, wdata=0xBEEF → IO bytes A0,A0,00,00,12,34; 4 latency beats with io_en=0; then BE,EF. 6 SCK rising edges; CE# low for 14*2 clk; one done pulse.
- Read, DIV8, rcmd=0x20, rlc=5, model drives 0x5A then 0xC3 at the data edges → rdata_o=0x5AC3 at done; 9 SCK rising edges; io_en=0 from latency onward.
- LC=0 read, DIV4 → ADDR goes directly to RDATA; 4 SCK rising edges; done pulse is observed.
- Back-to-back writes, recy=3, DIV16 → CE# high for ≥ 4*8 clk between bursts; second xfer_ready_o only after return to IDLE.
- en_i=0 with xfer_valid_i=1 → xfer_ready_o=0, ce stays 1. en_i dropped mid-ADDR → burst completes with done pulse.
- rst_n_i asserted mid-LATN → ce=1, sck=0, io_en=0 in the same cycle, no done. After release, a new read completes correctly.

Source files
------------

// File: rtl/psram_opi_core_pkg.sv
// Shared PSRAM definitions: FSM state encodings, prescaler codes and small
// helpers used by the OPI transaction engine and its SCK generator.
package psram_opi_core_pkg;

  localparam logic [3:0] PSRAM_FSM_IDLE  = 4'd0;
  localparam logic [3:0] PSRAM_FSM_TCSP  = 4'd1;
  localparam logic [3:0] PSRAM_FSM_INST  = 4'd2;
  localparam logic [3:0] PSRAM_FSM_ADDR  = 4'd3;
  localparam logic [3:0] PSRAM_FSM_LATN  = 4'd4;
  localparam logic [3:0] PSRAM_FSM_WDATA = 4'd5;
  localparam logic [3:0] PSRAM_FSM_RDATA = 4'd6;
  localparam logic [3:0] PSRAM_FSM_TCHD  = 4'd7;
  localparam logic [3:0] PSRAM_FSM_RECY  = 4'd8;

  localparam logic [1:0] PSRAM_PSCR_DIV4  = 2'b00;
  localparam logic [1:0] PSRAM_PSCR_DIV8  = 2'b01;
  localparam logic [1:0] PSRAM_PSCR_DIV16 = 2'b10;
  localparam logic [1:0] PSRAM_PSCR_DIV32 = 2'b11;

  // Half SCK period in system clocks.
  function automatic logic [4:0] psram_half_period(input logic [1:0] pscr);
    logic [4:0] h;
    case (pscr)
      PSRAM_PSCR_DIV4:  h = 5'd2;
      PSRAM_PSCR_DIV8:  h = 5'd4;
      PSRAM_PSCR_DIV16: h = 5'd8;
      default:          h = 5'd16;
    endcase
    return h;
  endfunction

  // States in which SCK toggles.
  function automatic logic psram_fsm_toggling(input logic [3:0] st);
    return (st == PSRAM_FSM_INST)  || (st == PSRAM_FSM_ADDR) ||
           (st == PSRAM_FSM_LATN)  || (st == PSRAM_FSM_WDATA) ||
           (st == PSRAM_FSM_RDATA);
  endfunction

endpackage

// File: rtl/psram_opi_core_sck_gen.sv
// Half-period timebase and SCK register for the OPI engine.
//   clk_i/rst_n_i : system clock, async active-low reset
//   pscr_i        : prescaler code (latched per burst by the caller)
//   run_i         : SCK toggles at edge points while high, held low otherwise
//   clear_i       : restart the half-period counter (state entry / idle)
//   launch_o      : hp_cnt == H/2-1 (output update point)
//   edge_o        : hp_cnt == H-1   (SCK edge / capture point)
//   sck_o         : registered SCK
module psram_sck_gen
  import psram_opi_core_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] pscr_i,
  input  logic       run_i,
  input  logic       clear_i,
  output logic       launch_o,
  output logic       edge_o,
  output logic       sck_o
);

  logic [3:0] hp_cnt_q, hp_cnt_d;
  logic       sck_q, sck_d;
  logic [4:0] half;
  logic [3:0] edge_pt, launch_pt;

  always_comb begin
    half      = psram_half_period(pscr_i);
    edge_pt   = 4'(half - 5'd1);
    launch_pt = 4'((half >> 1) - 5'd1);
    launch_o  = (hp_cnt_q == launch_pt);
    edge_o    = (hp_cnt_q == edge_pt);
  end

  always_comb begin
    hp_cnt_d = hp_cnt_q + 4'd1;
    if (clear_i || edge_o) hp_cnt_d = '0;
    sck_d = sck_q;
    if (!run_i)      sck_d = 1'b0;
    else if (edge_o) sck_d = ~sck_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hp_cnt_q <= '0;
      sck_q    <= 1'b0;
    end else begin
      hp_cnt_q <= hp_cnt_d;
      sck_q    <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/psram_opi_core.sv
// OPI DDR PSRAM transaction engine. Turns one accepted request into a
// complete 2-byte burst: CE# setup, command, address, latency, data,
// CE# hold and recovery, then a one-cycle done pulse.
//   clk_i, rst_n_i         : system clock, async active-low reset
//   en_i, pscr_i, tcsp_i, tchd_i, recy_i, wcmd_i, rcmd_i, wlc_i, rlc_i
//                          : latched configuration (pscr sampled on accept)
//   xfer_*                 : single-transfer request handshake and payload
//   rdata_o, done_o, busy_o: completion status
//   psram_*                : OPI pin bundle (SCK, CE#, IO[7:0], DQS)
module psram_opi_core
  import psram_opi_core_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 2,
  parameter int unsigned LC_WIDTH   = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  input  logic [1:0]          pscr_i,
  input  logic [1:0]          tcsp_i,
  input  logic [1:0]          tchd_i,
  input  logic [7:0]          recy_i,
  input  logic [7:0]          wcmd_i,
  input  logic [7:0]          rcmd_i,
  input  logic [LC_WIDTH-1:0] wlc_i,
  input  logic [LC_WIDTH-1:0] rlc_i,
  input  logic                xfer_valid_i,
  output logic                xfer_ready_o,
  input  logic                xfer_we_i,
  input  logic [31:0]         xfer_addr_i,
  input  logic [15:0]         xfer_wdata_i,
  output logic [15:0]         rdata_o,
  output logic                done_o,
  output logic                busy_o,
  output logic                psram_sck_o,
  output logic                psram_ce_o,
  output logic [7:0]          psram_io_en_o,
  output logic [7:0]          psram_io_out_o,
  input  logic [7:0]          psram_io_in_i,
  output logic                psram_dqs_en_o,
  output logic                psram_dqs_out_o,
  input  logic                psram_dqs_in_i
);

  localparam int unsigned BW = LC_WIDTH + 1;

  logic [3:0]          state_q, state_d;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [15:0]         wdata_q;
  logic [7:0]          cmd_q;
  logic [LC_WIDTH-1:0] lc_q;
  logic [1:0]          pscr_q;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [BW-1:0]       beat_last;
  logic [15:0]         rbuf_q, rdata_q;
  logic [7:0]          io_en_q, io_en_d, io_out_q, io_out_d;
  logic                dqs_en_q, dqs_en_d;
  logic                ce_q, done_q;

  logic accept, launch, edge_pt, sck, entering, beat_end;
  logic unused_inputs;

  // DQS input is not used for capture; address bit 0 is forced low.
  assign unused_inputs = ^{psram_dqs_in_i, xfer_addr_i[0]};

  assign accept       = (state_q == PSRAM_FSM_IDLE) && en_i && xfer_valid_i;
  assign xfer_ready_o = accept;

  always_comb begin
    beat_last = '0;
    case (state_q)
      PSRAM_FSM_TCSP:  beat_last = BW'(tcsp_i);
      PSRAM_FSM_INST:  beat_last = BW'(1);
      PSRAM_FSM_ADDR:  beat_last = BW'(3);
      PSRAM_FSM_LATN:  beat_last = {lc_q, 1'b0} - BW'(1);
      PSRAM_FSM_WDATA: beat_last = BW'(DATA_BYTES - 1);
      PSRAM_FSM_RDATA: beat_last = BW'(DATA_BYTES - 1);
      PSRAM_FSM_TCHD:  beat_last = BW'(tchd_i);
      PSRAM_FSM_RECY:  beat_last = BW'(recy_i);
      default:         beat_last = '0;
    endcase
  end

  assign beat_end = edge_pt && (bcnt_q == beat_last) && (state_q != PSRAM_FSM_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      PSRAM_FSM_IDLE:  if (accept) state_d = PSRAM_FSM_TCSP;
      PSRAM_FSM_TCSP:  if (beat_end) state_d = PSRAM_FSM_INST;
      PSRAM_FSM_INST:  if (beat_end) state_d = PSRAM_FSM_ADDR;
      PSRAM_FSM_ADDR:
        if (beat_end) begin
          if (lc_q != '0) state_d = PSRAM_FSM_LATN;
          else            state_d = we_q ? PSRAM_FSM_WDATA : PSRAM_FSM_RDATA;
        end
      PSRAM_FSM_LATN:
        if (beat_end) state_d = we_q ? PSRAM_FSM_WDATA : PSRAM_FSM_RDATA;
      PSRAM_FSM_WDATA: if (beat_end) state_d = PSRAM_FSM_TCHD;
      PSRAM_FSM_RDATA: if (beat_end) state_d = PSRAM_FSM_TCHD;
      PSRAM_FSM_TCHD:  if (beat_end) state_d = PSRAM_FSM_RECY;
      PSRAM_FSM_RECY:  if (beat_end) state_d = PSRAM_FSM_IDLE;
      default:         state_d = PSRAM_FSM_IDLE;
    endcase
  end

  assign entering = (state_d != state_q);

  always_comb begin
    bcnt_d = bcnt_q;
    if (entering)     bcnt_d = '0;
    else if (edge_pt) bcnt_d = bcnt_q + BW'(1);
  end

  psram_sck_gen u_sck_gen (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .pscr_i   (pscr_q),
    .run_i    (psram_fsm_toggling(state_q)),
    .clear_i  ((state_q == PSRAM_FSM_IDLE) || entering),
    .launch_o (launch),
    .edge_o   (edge_pt),
    .sck_o    (sck)
  );

  // Pin outputs only change at launch points, mid-beat, so they are stable
  // around every SCK edge; non-data beats drive IO/DQS disabled.
  always_comb begin
    io_en_d  = io_en_q;
    io_out_d = io_out_q;
    dqs_en_d = dqs_en_q;
    if (launch && (state_q != PSRAM_FSM_IDLE)) begin
      io_en_d  = '0;
      io_out_d = '0;
      dqs_en_d = 1'b0;
      case (state_q)
        PSRAM_FSM_INST: begin
          io_en_d  = '1;
          io_out_d = cmd_q;
        end
        PSRAM_FSM_ADDR: begin
          io_en_d = '1;
          case (bcnt_q[1:0])
            2'd0:    io_out_d = addr_q[31:24];
            2'd1:    io_out_d = addr_q[23:16];
            2'd2:    io_out_d = addr_q[15:8];
            default: io_out_d = addr_q[7:0];
          endcase
        end
        PSRAM_FSM_LATN:  dqs_en_d = we_q && (bcnt_q == beat_last);
        PSRAM_FSM_WDATA: begin
          io_en_d  = '1;
          io_out_d = (bcnt_q == '0) ? wdata_q[15:8] : wdata_q[7:0];
          dqs_en_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= PSRAM_FSM_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cmd_q    <= '0;
      lc_q     <= '0;
      pscr_q   <= PSRAM_PSCR_DIV4;
      bcnt_q   <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
      io_en_q  <= '0;
      io_out_q <= '0;
      dqs_en_q <= 1'b0;
      ce_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      io_en_q  <= io_en_d;
      io_out_q <= io_out_d;
      dqs_en_q <= dqs_en_d;
      ce_q     <= (state_d == PSRAM_FSM_IDLE) || (state_d == PSRAM_FSM_RECY);
      done_q   <= (state_q == PSRAM_FSM_TCHD) && (state_d == PSRAM_FSM_RECY);
      if (accept) begin
        we_q    <= xfer_we_i;
        addr_q  <= {xfer_addr_i[31:1], 1'b0};
        wdata_q <= xfer_wdata_i;
        cmd_q   <= xfer_we_i ? wcmd_i : rcmd_i;
        lc_q    <= xfer_we_i ? wlc_i : rlc_i;
        pscr_q  <= pscr_i;
      end
      if ((state_q == PSRAM_FSM_RDATA) && edge_pt) begin
        if (bcnt_q == '0) rbuf_q[15:8] <= psram_io_in_i;
        else              rbuf_q[7:0]  <= psram_io_in_i;
      end
      if ((state_q == PSRAM_FSM_TCHD) && (state_d == PSRAM_FSM_RECY) && !we_q)
        rdata_q <= rbuf_q;
    end
  end

  assign rdata_o         = rdata_q;
  assign done_o          = done_q;
  assign busy_o          = (state_q != PSRAM_FSM_IDLE);
  assign psram_sck_o     = sck;
  assign psram_ce_o      = ce_q;
  assign psram_io_en_o   = io_en_q;
  assign psram_io_out_o  = io_out_q;
  assign psram_dqs_en_o  = dqs_en_q;
  assign psram_dqs_out_o = 1'b0;

endmodule

// File: tb/tb_psram_opi_core.sv
// Scoreboard bench for psram_opi_core: each request pushes its expected pin
// trace and completion data; a negedge monitor captures IO at every SCK
// transition and checks it when done_o fires. It also plays the device for
// reads by driving IO input bytes during the data beats.
module tb_psram_opi_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  pscr, tcsp, tchd;
  logic [7:0]  recy, wcmd, rcmd, wlc, rlc;
  logic        xv, xw;
  logic [31:0] xa;
  logic [15:0] xd;
  logic [7:0]  io_in;
  logic        ready, done, busy, sck, ce, dqs_en, dqs_out;
  logic [15:0] rdata;
  logic [7:0]  io_en, io_out;

  always #5 clk = ~clk;

  psram_opi_core #(.DATA_BYTES(2), .LC_WIDTH(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .pscr_i(pscr), .tcsp_i(tcsp),
    .tchd_i(tchd), .recy_i(recy), .wcmd_i(wcmd), .rcmd_i(rcmd), .wlc_i(wlc),
    .rlc_i(rlc), .xfer_valid_i(xv), .xfer_ready_o(ready), .xfer_we_i(xw),
    .xfer_addr_i(xa), .xfer_wdata_i(xd), .rdata_o(rdata), .done_o(done),
    .busy_o(busy), .psram_sck_o(sck), .psram_ce_o(ce), .psram_io_en_o(io_en),
    .psram_io_out_o(io_out), .psram_io_in_i(io_in), .psram_dqs_en_o(dqs_en),
    .psram_dqs_out_o(dqs_out), .psram_dqs_in_i(1'b0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard queues, one entry per burst (edges: nedge entries per burst).
  int          q_rise[$], q_celow[$], q_nedge[$];
  logic [16:0] q_rd[$];          // bit16 = read, compare rdata
  logic [16:0] q_edge[$];        // {dqs_en, io_en, io_out}

  // Device-model state for the burst in flight.
  logic       cur_we;
  int         cur_lc;
  logic [7:0] cur_b0, cur_b1;
  int         gap_exp = 0;

  task automatic expect_burst(input logic we, input logic [7:0] cmd, input logic [31:0] eaddr,
                              input logic [15:0] wd, input int lc, input int rise,
                              input int celow, input logic [15:0] rd);
    logic [7:0] ab;
    q_rise.push_back(rise);
    q_celow.push_back(celow);
    q_rd.push_back({~we, rd});
    q_nedge.push_back(8 + 2 * lc);
    q_edge.push_back({1'b0, 8'hFF, cmd});
    q_edge.push_back({1'b0, 8'hFF, cmd});
    for (int i = 0; i < 4; i++) begin
      ab = eaddr[31 - 8 * i -: 8];
      q_edge.push_back({1'b0, 8'hFF, ab});
    end
    for (int i = 0; i < 2 * lc; i++)
      q_edge.push_back({we && (i == 2 * lc - 1), 8'h00, 8'h00});
    if (we) begin
      q_edge.push_back({1'b1, 8'hFF, wd[15:8]});
      q_edge.push_back({1'b1, 8'hFF, wd[7:0]});
    end else begin
      q_edge.push_back({1'b0, 8'h00, 8'h00});
      q_edge.push_back({1'b0, 8'h00, 8'h00});
    end
    cur_we = we;
    cur_lc = lc;
    cur_b0 = rd[15:8];
    cur_b1 = rd[7:0];
  endtask

  // Monitor: samples on the falling clock edge.
  initial begin
    logic        sck_prev = 1'b0, ce_prev = 1'b1, done_prev = 1'b0;
    int          rises = 0, toggles = 0, celow = 0, ce_high = 0;
    logic [16:0] cap[$];
    int          n;
    logic [16:0] e, r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sck_prev = 1'b0; ce_prev = 1'b1; done_prev = 1'b0;
        rises = 0; toggles = 0; celow = 0; ce_high = 0;
        cap.delete();
      end else begin
        if (ready) check("ready_only_when_idle", {31'd0, busy}, 32'd0);
        if (ce_prev && !ce) begin
          if (gap_exp > 0) begin
            check("ce_high_gap", {31'd0, ce_high >= gap_exp}, 32'd1);
            gap_exp = 0;
          end
          ce_high = 0;
        end
        if (ce) ce_high++;
        else    celow++;
        ce_prev = ce;
        if (sck != sck_prev) begin
          toggles++;
          if (sck) rises++;
          cap.push_back({dqs_en, io_en, io_out});
          if (!cur_we && toggles == 6 + 2 * cur_lc) io_in = cur_b0;
          else if (!cur_we && toggles == 7 + 2 * cur_lc) io_in = cur_b1;
        end
        sck_prev = sck;
        if (done) begin
          check("done_single_cycle", {31'd0, done_prev}, 32'd0);
          check("done_expected", {31'd0, q_rise.size() != 0}, 32'd1);
          if (q_rise.size() != 0) begin
            check("sck_rises", rises, q_rise.pop_front());
            n = q_celow.pop_front();
            if (n != 0) check("ce_low_clks", celow, n);
            r = q_rd.pop_front();
            if (r[16]) check("rdata", {16'd0, rdata}, {16'd0, r[15:0]});
            n = q_nedge.pop_front();
            check("edge_count", cap.size(), n);
            for (int i = 0; i < n; i++) begin
              e = q_edge.pop_front();
              if (i < cap.size()) begin
                check($sformatf("io_en[%0d]", i), {24'd0, cap[i][15:8]}, {24'd0, e[15:8]});
                check($sformatf("dqs_en[%0d]", i), {31'd0, cap[i][16]}, {31'd0, e[16]});
                if (e[15:8] != 8'h00)
                  check($sformatf("io_out[%0d]", i), {24'd0, cap[i][7:0]}, {24'd0, e[7:0]});
              end
            end
          end
          rises = 0; toggles = 0; celow = 0;
          cap.delete();
        end
        done_prev = done;
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [15:0] wd);
    logic accepted = 1'b0;
    @(negedge clk);
    xw = we; xa = addr; xd = wd; xv = 1'b1;
    for (int i = 0; i < 2000 && !accepted; i++) begin
      #1;
      if (ready) begin
        @(posedge clk);
        #1 xv = 1'b0;
        accepted = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    xv = 1'b0;
    check("accept_in_time", {31'd0, accepted}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && q_rise.size() != 0; i++) @(negedge clk);
    check("burst_completed", q_rise.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; pscr = 2'b00; tcsp = 2'd0; tchd = 2'd0; recy = 8'd0;
    wcmd = 8'hA0; rcmd = 8'h20; wlc = 8'd2; rlc = 8'd5;
    xv = 1'b0; xw = 1'b0; xa = '0; xd = '0; io_in = '0;
    cur_we = 1'b1; cur_lc = 0; cur_b0 = '0; cur_b1 = '0;
    repeat (3) @(negedge clk);
    check("rst_sck", {31'd0, sck}, 32'd0);
    check("rst_ce", {31'd0, ce}, 32'd1);
    check("rst_io_en", {24'd0, io_en}, 32'd0);
    check("rst_io_out", {24'd0, io_out}, 32'd0);
    check("rst_dqs_en", {31'd0, dqs_en}, 32'd0);
    check("rst_dqs_out", {31'd0, dqs_out}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write, DIV4, LC=2: 14 beats of CE# low at 2 clk each.
    expect_burst(1'b1, 8'hA0, 32'h0000_1234, 16'hBEEF, 2, 6, 28, 16'h0000);
    issue(1'b1, 32'h0000_1234, 16'hBEEF);
    drain();

    // Read, DIV8, LC=5: 20 beats at 4 clk.
    pscr = 2'b01;
    expect_burst(1'b0, 8'h20, 32'h00AB_CD00, 16'h0000, 5, 9, 80, 16'h5AC3);
    issue(1'b0, 32'h00AB_CD00, 16'h0000);
    drain();

    // Read, DIV4, LC=0, odd address serviced as even: 10 beats at 2 clk.
    pscr = 2'b00; rlc = 8'd0;
    expect_burst(1'b0, 8'h20, 32'h0000_ABCC, 16'h0000, 0, 4, 20, 16'h1122);
    issue(1'b0, 32'h0000_ABCD, 16'h0000);
    drain();

    // Back-to-back writes, DIV16, recy=3: CE# high >= 4*8 clk between.
    pscr = 2'b10; recy = 8'd3;
    expect_burst(1'b1, 8'hA0, 32'h0000_0010, 16'h1111, 2, 6, 112, 16'h0000);
    expect_burst(1'b1, 8'hA0, 32'h0000_0020, 16'h2222, 2, 6, 112, 16'h0000);
    issue(1'b1, 32'h0000_0010, 16'h1111);
    repeat (2) @(negedge clk);
    gap_exp = 32;
    issue(1'b1, 32'h0000_0020, 16'h2222);
    drain();
    check("gap_checked", gap_exp, 0);

    // Disabled: request ignored.
    pscr = 2'b00; recy = 8'd0; en = 1'b0;
    @(negedge clk);
    xv = 1'b1; xw = 1'b1; xa = 32'h40; xd = 16'h7777;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("disabled_ready", {31'd0, ready}, 32'd0);
      check("disabled_ce", {31'd0, ce}, 32'd1);
      @(negedge clk);
    end
    xv = 1'b0;
    en = 1'b1;

    // en dropped during ADDR: burst still completes.
    expect_burst(1'b1, 8'hA0, 32'h0000_5678, 16'hCAFE, 2, 6, 28, 16'h0000);
    issue(1'b1, 32'h0000_5678, 16'hCAFE);
    repeat (8) @(negedge clk);
    en = 1'b0;
    drain();
    en = 1'b1;

    // Reset during LATN of a DIV8 LC=5 read, then a clean read.
    pscr = 2'b01; rlc = 8'd5;
    expect_burst(1'b0, 8'h20, 32'h0000_0100, 16'h0000, 5, 9, 80, 16'hFFFF);
    issue(1'b0, 32'h0000_0100, 16'h0000);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ce", {31'd0, ce}, 32'd1);
    check("midrst_sck", {31'd0, sck}, 32'd0);
    check("midrst_io_en", {24'd0, io_en}, 32'd0);
    check("midrst_dqs_en", {31'd0, dqs_en}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rdata", {16'd0, rdata}, 32'd0);
    q_rise.delete(); q_celow.delete(); q_rd.delete(); q_nedge.delete(); q_edge.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    rlc = 8'd2;
    expect_burst(1'b0, 8'h20, 32'h0000_0200, 16'h0000, 2, 6, 56, 16'h3CA5);
    issue(1'b0, 32'h0000_0200, 16'h0000);
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
